// File: rtl/taillight_pkg.sv
// Shared types and helpers for the tail-light sequencer.
package taillight_pkg;

  // Step position within a turn lives in a separate counter.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TURN_L  = 3'd1,
    TURN_R  = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
  } state_t;

  // Lower-k-ones mask, clamped to the lamp count (lamps <= 31).
  function automatic logic [31:0] therm(input int unsigned k, input int unsigned lamps);
    logic [31:0] m;
    if (k >= lamps) m = (32'd1 << lamps) - 32'd1;
    else            m = (32'd1 << k) - 32'd1;
    return m;
  endfunction

endpackage

// File: rtl/taillight_seq_if.sv
// Switch requests in, lamp drives out.
interface taillight_seq_if #(parameter int LAMPS = 3);
  logic             left;
  logic             right;
  logic             hazard;
  logic             brake;
  logic [LAMPS-1:0] lamps_l;
  logic [LAMPS-1:0] lamps_r;

  modport master (output left, right, hazard, brake, input lamps_l, lamps_r);
  modport slave  (input left, right, hazard, brake, output lamps_l, lamps_r);
endinterface

// File: rtl/taillight_seq_prescaler.sv
// Animation step prescaler: one-cycle tick every STEP_DIV clocks.
module step_prescaler #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Divide-by-1 ties tick high; the counter then sits at zero.
  assign tick = (STEP_DIV == 1) ? 1'b1 : (cnt_q == LAST);

  // Wrap to zero on the tick cycle.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/taillight_seq.sv
// Thunderbird-style tail-light sequencer: thermometer turn, hazard flash, brake overlay.
module taillight_seq
  import taillight_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  taillight_seq_if.slave   bus
);
  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0]    LAST = SW'(LAMPS);
  localparam logic [LAMPS-1:0] ONES = '1;

  logic             tick;
  state_t           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [LAMPS-1:0] lamps_l_q, lamps_l_d;
  logic [LAMPS-1:0] lamps_r_q, lamps_r_d;
  logic [31:0]      mask;

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Next state: advance only on tick; a running turn ignores side changes.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (tick) begin
      case (state_q)
        IDLE, HAZ_OFF: begin
          step_d = '0;
          // Both sides at once is treated as hazard.
          if (bus.hazard || (bus.left && bus.right)) state_d = HAZ_ON;
          else if (bus.left)  begin state_d = TURN_L; step_d = SW'(1); end
          else if (bus.right) begin state_d = TURN_R; step_d = SW'(1); end
          else                state_d = IDLE;
        end
        TURN_L, TURN_R: begin
          if (bus.hazard) begin
            state_d = HAZ_ON;
            step_d  = '0;
          end else if (step_q == LAST) begin
            state_d = IDLE;
            step_d  = '0;
          end else begin
            step_d  = step_q + 1'b1;
          end
        end
        HAZ_ON:  state_d = HAZ_OFF;
        default: begin state_d = IDLE; step_d = '0; end
      endcase
    end
  end

  // Lamp decode from the next state so a transition shows on the edge taking it.
  always_comb begin
    mask      = therm({{(32-SW){1'b0}}, step_d}, LAMPS);
    lamps_l_d = '0;
    lamps_r_d = '0;
    case (state_d)
      IDLE: begin
        lamps_l_d = bus.brake ? ONES : '0;
        lamps_r_d = bus.brake ? ONES : '0;
      end
      TURN_L: begin
        lamps_l_d = mask[LAMPS-1:0];
        lamps_r_d = bus.brake ? ONES : '0;
      end
      TURN_R: begin
        lamps_l_d = bus.brake ? ONES : '0;
        lamps_r_d = mask[LAMPS-1:0];
      end
      HAZ_ON: begin
        lamps_l_d = ONES;
        lamps_r_d = ONES;
      end
      default: ;
    endcase
  end

  // State, step and lamp registers; reset darkens lamps immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      step_q    <= '0;
      lamps_l_q <= '0;
      lamps_r_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      lamps_l_q <= lamps_l_d;
      lamps_r_q <= lamps_r_d;
    end
  end

  assign bus.lamps_l = lamps_l_q;
  assign bus.lamps_r = lamps_r_q;
endmodule
